shift_add_mult: RTL and testbench

- Parametrised sequential unsigned multiplier using the shift-and-add method.
- Computes one `WIDTH x WIDTH` product over several cycles with a single `WIDTH`-bit ripple adder built from full-adder cells, instead of a full combinational array.
- Sits in the `comb/multiplier` family as the area-optimised, handshaked successor to the combinational adder cells.
- Uses ready/valid handshakes on both input and output, so it can stall inside a datapath pipeline.

---
 rtl/shift_add_mult_pkg.sv | 27 ++
 rtl/rca_nbit.sv | 30 +++
 rtl/shift_add_mult.sv | 145 ++++++++++++++
 tb/tb_shift_add_mult.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift_add_mult sequential multiplier:
//   state_t        - FSM state encoding (IDLE, CALC, DONE)
//   MULT_WIDTH_MAX - largest supported operand width
//   clog2()        - width of a counter able to count 0..value-1 (min 1 bit)
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH_MAX = 32;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// -----------------------------------------------------------------------------
// rca_nbit
// WIDTH-bit ripple-carry adder built as a chain of full-adder cells.
// Carry-in is tied to zero; the final carry is exposed so no product bit is lost.
// Ports:
//   a, b  in  WIDTH : addends
//   sum   out WIDTH : a + b (low WIDTH bits)
//   cout  out 1     : carry out of the MSB cell
// -----------------------------------------------------------------------------
module rca_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// -----------------------------------------------------------------------------
// shift_add_mult
// Sequential unsigned WIDTH x WIDTH multiplier using shift-and-add: one
// partial-product addition per cycle through a single rca_nbit, with
// ready/valid handshakes on both sides.
// Ports:
//   clk        in  1       : clock, rising edge
//   rst        in  1       : synchronous active-high reset
//   in_valid   in  1       : operands valid
//   in_ready   out 1       : accepting operands (IDLE only)
//   in_A       in  WIDTH   : multiplicand
//   in_B       in  WIDTH   : multiplier
//   out_valid  out 1       : out_P holds a finished product (DONE)
//   out_ready  in  1       : consumer takes the product
//   out_P      out 2*WIDTH : registered product
//   busy       out 1       : CALC or DONE
// Configuration macro:
//   SHIFT_ADD_MULT_EARLY_TERM_EN - finish CALC as soon as the remaining
//   multiplier bits are all zero, applying the leftover shift in one step.
// -----------------------------------------------------------------------------
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_A,
    input  logic [WIDTH-1:0]   in_B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_P,
    output logic               busy
);

    localparam int CNT_W = clog2(WIDTH);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   out_p_q, out_p_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   acc_shift;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_iter;

    // Upper half of acc is the running partial product; lower half holds the
    // multiplier bits still to be consumed, LSB first.
    assign addend = acc_q[0] ? mcand_q : '0;

    rca_nbit #(
        .WIDTH(WIDTH)
    ) u_rca (
        .a   (acc_q[2*WIDTH-1:WIDTH]),
        .b   (addend),
        .sum (sum),
        .cout(cout)
    );

    // Carry enters the MSB as the whole accumulator shifts right by one.
    assign acc_shift = {cout, sum, acc_q[WIDTH-1:1]};

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    // After cnt shifts only acc[WIDTH-1-cnt:1] are multiplier bits still
    // pending above the current LSB; the rest is already-shifted product.
    logic [WIDTH-2:0] rem_mask;

    assign rem_mask  = {(WIDTH-1){1'b1}} >> cnt_q;
    assign last_iter = ((acc_q[WIDTH-1:1] & rem_mask) == '0);
    assign acc_next  = acc_shift >> ((WIDTH - 1) - int'(cnt_q));
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_next  = acc_shift;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = in_A;
                    acc_d   = {{WIDTH{1'b0}}, in_B};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    out_p_d = acc_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset too, so out_P reads 0 after reset
    // and no stale partial result can ever be observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_p_q <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only registered state: no path from in_valid/out_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_P     = out_p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult
// Self-checking bench for shift_add_mult at WIDTH=8: a vector table of
// directed products, hand-written backpressure and mid-CALC reset sequences,
// and 1000 random products against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_add_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_A;
    logic [W-1:0]   in_B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_P;
    logic           busy;

    int n_tests;
    int n_fail;
    int cyc;
    int last_accept;
    bit have_prev;

    shift_add_mult #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_A     (in_A),
        .in_B     (in_B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_P    (out_P),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of CALC cycles the spec prescribes for a given multiplier.
    function automatic int calc_len(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        int k;
        k = -1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) k = i;
        end
        return (k < 0) ? 1 : k + 1;
`else
        return W;
`endif
    endfunction

    // One full transaction: accept, wait for result, optional stall, pop.
    task automatic do_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp_p,
                         input int stall);
        int wait_cnt;
        int lat;
        logic [2*W-1:0] held;

        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);

        in_A     = a;
        in_B     = b;
        in_valid = 1'b1;
        tick();
        if (have_prev) begin
`ifndef SHIFT_ADD_MULT_EARLY_TERM_EN
            check({tag, " accept interval >= W+2"},
                  32'((cyc - last_accept) >= W + 2), 32'd1);
`endif
        end
        last_accept = cyc;
        have_prev   = 1'b1;
        in_valid    = 1'b0;
        in_A        = W'($urandom);
        in_B        = W'($urandom);
        check({tag, " busy after accept"}, 32'(busy), 32'd1);

        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " latency (edges accept->out_valid)"}, 32'(lat), 32'(calc_len(b)));
        check({tag, " product"}, 32'(out_P), 32'(exp_p));

        held = out_P;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            in_A     = W'($urandom);
            in_B     = W'($urandom);
            tick();
            check({tag, " stall out_valid held"}, 32'(out_valid), 32'd1);
            check({tag, " stall out_P stable"}, 32'(out_P), 32'(held));
            check({tag, " stall in_ready low"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after pop"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid after pop"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_tests     = 0;
        n_fail      = 0;
        have_prev   = 1'b0;
        last_accept = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_A        = '0;
        in_B        = '0;
        out_ready   = 1'b0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd77,  b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
        vecs[5] = '{a: 8'd255, b: 8'd128, p: 16'd32640};
        vecs[6] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
        vecs[7] = '{a: 8'd3,   b: 8'd5,   p: 16'd15};

        // Reset state
        tick();
        tick();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_P", 32'(out_P), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vector table
        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 0);
        end

        // Output backpressure: 5 stalled cycles in DONE with stray in_valid,
        // followed by a product that must be unaffected by the stray inputs.
        do_op("backpressure", 8'd200, 8'd99, 16'd19800, 5);
        do_op("after backpressure", 8'd17, 8'd19, 16'd323, 0);

        // Reset mid-CALC: accept in T, assert rst during T+4.
        in_A     = 8'd250;
        in_B     = 8'd251;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset out_P", 32'(out_P), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        have_prev = 1'b0;
        do_op("after midreset 3x5", 8'd3, 8'd5, 16'd15, 0);

        // Random back-to-back products with random stalls
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 15) == 0) rb = W'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) ra = '0;
            do_op($sformatf("rand%0d", n), ra, rb,
                  (2*W)'(int'(ra) * int'(rb)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
